// File: rtl/rob_commit.sv
// rob_commit: in-order retire buffer at the consumer end of the rename interface.
//
// Accepts renamed instructions, collects out-of-order completion writebacks,
// resolves branches oldest-first and retires entries strictly in program order.
// Each retire returns the physical destination to rename via p_commit_o.
// A mispredict discards every entry younger than the resolving branch.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   rinstr_i       renamed instruction (valid, rd, rs1, rs2, is_branch)
//   rob_full_o     no free entry; rename must hold rinstr_i.valid low
//   alloc_tag_o    tag the current rinstr_i receives if accepted (tail pointer)
//   wb_valid_i     completion strobe
//   wb_tag_i       tag of the completing entry
//   br_result_i    {valid, hit} for the oldest unresolved branch
//   p_commit_o     registered {valid, idx, ready} of the retired destination
//   empty_o        no occupied entries
//
// Optional feature (macro ROB_PERF_EN):
//   retired_cnt_o  saturating count of retired entries
//   flushed_cnt_o  saturating count of entries discarded by mispredicts
//
// DEPTH must be a power of two (pointers wrap by natural overflow).

package rob_commit_pkg;

    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
        logic       ready;
    } p_reg_t;

    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
    } rd_t;

    typedef struct packed {
        logic   valid;
        rd_t    rd;
        p_reg_t rs1;
        p_reg_t rs2;
        logic   is_branch;
    } rinstr_t;

    typedef struct packed {
        logic valid;
        logic hit;
    } br_result_t;

endpackage

module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  rinstr_t          rinstr_i,
    output logic             rob_full_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic             wb_valid_i,
    input  logic [TAG_W-1:0] wb_tag_i,
    input  br_result_t       br_result_i,
    output p_reg_t           p_commit_o,
    output logic             empty_o
`ifdef ROB_PERF_EN
    ,
    output logic [31:0]      retired_cnt_o,
    output logic [31:0]      flushed_cnt_o
`endif
);

    localparam int unsigned CntW = TAG_W + 1;

    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] rd_valid_q, rd_valid_d;
    logic [DEPTH-1:0] is_br_q, is_br_d;
    logic [DEPTH-1:0] resolved_q, resolved_d;
    logic [5:0]       rd_idx_q [DEPTH];
    logic [5:0]       rd_idx_d [DEPTH];

    p_reg_t p_commit_q, p_commit_d;

    logic             full, do_retire, do_alloc, br_fire, br_miss;
    logic             br_found;
    logic [TAG_W-1:0] brk, brk_off;

    // Source operands are consumed by issue, not by the retire buffer.
    logic unused_rs;
    assign unused_rs = ^{rinstr_i.rs1, rinstr_i.rs2};

    assign full        = (count_q == CntW'(DEPTH));
    assign rob_full_o  = full;
    assign empty_o     = (count_q == '0);
    assign alloc_tag_o = tail_q;
    assign p_commit_o  = p_commit_q;

    // Oldest occupied, unresolved branch, searched from head in program order.
    always_comb begin
        br_found = 1'b0;
        brk      = '0;
        brk_off  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!br_found && (CntW'(i) < count_q)
                && busy_q[head_q + TAG_W'(i)]
                && is_br_q[head_q + TAG_W'(i)]
                && !resolved_q[head_q + TAG_W'(i)]) begin
                br_found = 1'b1;
                brk      = head_q + TAG_W'(i);
                brk_off  = TAG_W'(i);
            end
        end
    end

    assign do_retire = busy_q[head_q] && done_q[head_q];
    assign br_fire   = br_result_i.valid && br_found;
    assign br_miss   = br_fire && !br_result_i.hit;
    // An allocation racing a mispredict is on the wrong path.
    assign do_alloc  = rinstr_i.valid && !full && !br_miss;

    always_comb begin
        busy_d     = busy_q;
        done_d     = done_q;
        rd_valid_d = rd_valid_q;
        is_br_d    = is_br_q;
        resolved_d = resolved_q;
        rd_idx_d   = rd_idx_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        p_commit_d = '0;

        if (wb_valid_i && busy_q[wb_tag_i]) begin
            done_d[wb_tag_i] = 1'b1;
        end

        if (br_fire) begin
            resolved_d[brk] = 1'b1;
            done_d[brk]     = 1'b1;
        end

        // Clearing after the writeback update drops writebacks to flushed entries.
        if (br_miss) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((CntW'(i) > CntW'(brk_off)) && (CntW'(i) < count_q)) begin
                    busy_d[head_q + TAG_W'(i)]     = 1'b0;
                    done_d[head_q + TAG_W'(i)]     = 1'b0;
                    resolved_d[head_q + TAG_W'(i)] = 1'b0;
                end
            end
        end

        if (do_alloc) begin
            busy_d[tail_q]     = 1'b1;
            done_d[tail_q]     = !rinstr_i.rd.valid && !rinstr_i.is_branch;
            rd_valid_d[tail_q] = rinstr_i.rd.valid;
            rd_idx_d[tail_q]   = rinstr_i.rd.idx;
            is_br_d[tail_q]    = rinstr_i.is_branch;
            resolved_d[tail_q] = 1'b0;
        end

        if (do_retire) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + TAG_W'(1);
            p_commit_d     = '{valid: rd_valid_q[head_q], idx: rd_idx_q[head_q], ready: 1'b1};
        end

        if (br_miss) begin
            tail_d  = brk + TAG_W'(1);
            count_d = CntW'(brk_off) + CntW'(1) - CntW'(do_retire);
        end else begin
            tail_d  = do_alloc ? tail_q + TAG_W'(1) : tail_q;
            count_d = count_q + CntW'(do_alloc) - CntW'(do_retire);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            done_q     <= '0;
            rd_valid_q <= '0;
            is_br_q    <= '0;
            resolved_q <= '0;
            p_commit_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_idx_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            is_br_q    <= is_br_d;
            resolved_q <= resolved_d;
            p_commit_q <= p_commit_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

`ifdef ROB_PERF_EN
    logic [31:0]     retired_cnt_q, flushed_cnt_q;
    logic [CntW-1:0] flush_num;
    logic [32:0]     flush_sum;

    // Entries strictly younger than the mispredicted branch.
    assign flush_num = br_miss ? (count_q - CntW'(brk_off) - CntW'(1)) : '0;
    assign flush_sum = {1'b0, flushed_cnt_q} + 33'(flush_num);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retired_cnt_q <= '0;
            flushed_cnt_q <= '0;
        end else begin
            if (do_retire && (retired_cnt_q != '1)) begin
                retired_cnt_q <= retired_cnt_q + 32'd1;
            end
            flushed_cnt_q <= flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end

    assign retired_cnt_o = retired_cnt_q;
    assign flushed_cnt_o = flushed_cnt_q;
`endif

endmodule
